fetch_decode_ctrl: RTL and testbench

Multi-cycle fetch/decode controller and successor to the single-cycle controller. It owns the PC and fetches through a request/valid handshake to variable-latency instruction memory. Each instruction is held in an instruction register (IR) and decoded into the existing datapath controls (regfile, ALU, data memory). Load wait length and PC/immediate widths are parametrised.

---
 rtl/fetch_decode_ctrl_if.sv | 13 +
 rtl/fetch_decode_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_decode_ctrl_if.sv
// Instruction-memory fetch handshake between fetch_decode_ctrl (master) and imem (slave).
interface fetch_decode_ctrl_if #(
    parameter int PC_WIDTH = 8,
    parameter int WIDTH    = 32
);
    logic                imem_req;
    logic [PC_WIDTH-1:0] imem_addr;
    logic                imem_valid;
    logic [WIDTH-1:0]    imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_valid, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_valid, output imem_rdata);
endinterface

// File: rtl/fetch_decode_ctrl.sv
// Multi-cycle fetch/decode controller: PC, IR, request/valid fetch, decode into datapath controls.
// Optional ILLEGAL_TRAP_EN: an illegal opcode halts the core at the faulting PC until reset.
module fetch_decode_ctrl #(
    parameter int                  PC_WIDTH  = 8,
    parameter int                  WIDTH     = 32,
    parameter int                  IMM_WIDTH = 12,
    parameter int                  RS_WIDTH  = 5,
    parameter int                  ALU_WIDTH = 4,
    parameter int                  LOAD_WAIT = 1,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    fetch_decode_ctrl_if.master    imem,
    input  logic                   zero,
    output logic [RS_WIDTH-1:0]    rs1,
    output logic [RS_WIDTH-1:0]    rs2,
    output logic [RS_WIDTH-1:0]    rd,
    output logic [IMM_WIDTH-1:0]   imm,
    output logic [ALU_WIDTH-1:0]   alu_control,
    output logic                   alu_src,
    output logic                   mem_to_reg,
    output logic                   mem_write,
    output logic                   reg_write,
    output logic                   jal_src,
    output logic [PC_WIDTH-1:0]    ra,
    output logic [PC_WIDTH-1:0]    pc,
    output logic                   instr_valid,
    output logic                   stall,
    output logic                   illegal
);
    localparam int CNT_W = (LOAD_WAIT > 1) ? $clog2(LOAD_WAIT) : 1;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [ALU_WIDTH-1:0] ALU_AND = ALU_WIDTH'(4'b0000);
    localparam logic [ALU_WIDTH-1:0] ALU_OR  = ALU_WIDTH'(4'b0001);
    localparam logic [ALU_WIDTH-1:0] ALU_ADD = ALU_WIDTH'(4'b0010);
    localparam logic [ALU_WIDTH-1:0] ALU_SRL = ALU_WIDTH'(4'b0011);
    localparam logic [ALU_WIDTH-1:0] ALU_XOR = ALU_WIDTH'(4'b0100);
    localparam logic [ALU_WIDTH-1:0] ALU_SUB = ALU_WIDTH'(4'b0110);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_LOAD_WT, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0]    ir_q, ir_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm32;
    logic signed [31:0] off_words;
    logic is_lw, is_sw, is_br, is_r, is_i, is_jal, dec_illegal, taken;
    logic [ALU_WIDTH-1:0] dec_alu;

    assign opcode = ir_q[6:0];
    assign funct3 = ir_q[14:12];
    assign funct7 = ir_q[31:25];
    assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
    assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
    assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
    assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

    // NOTE: every variable written in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        is_lw = 1'b0; is_sw = 1'b0; is_br = 1'b0; is_r = 1'b0; is_i = 1'b0; is_jal = 1'b0;
        dec_illegal = 1'b0;
        dec_alu     = ALU_AND;
        imm32       = '0;
        case (opcode)
            OP_LW:  begin is_lw = 1'b1; imm32 = imm_i; dec_alu = ALU_ADD; end
            OP_SW:  begin is_sw = 1'b1; imm32 = imm_s; dec_alu = ALU_ADD; end
            OP_BR:  begin
                is_br = 1'b1; imm32 = imm_b; dec_alu = ALU_SUB;
                dec_illegal = (funct3[2:1] != 2'b00);
            end
            OP_R:   begin
                is_r = 1'b1;
                case (funct3)
                    3'b000: begin
                        if (funct7 == 7'b0000000)      dec_alu = ALU_ADD;
                        else if (funct7 == 7'b0100000) dec_alu = ALU_SUB;
                        else                           dec_illegal = 1'b1;
                    end
                    3'b100:  dec_alu = ALU_XOR;
                    3'b101:  dec_alu = ALU_SRL;
                    3'b110:  dec_alu = ALU_OR;
                    3'b111:  dec_alu = ALU_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_I:   begin
                is_i = 1'b1; imm32 = imm_i;
                case (funct3)
                    3'b000:  dec_alu = ALU_ADD;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b110:  dec_alu = ALU_OR;
                    3'b111:  dec_alu = ALU_AND;
                    default: dec_illegal = 1'b1;
                endcase
            end
            OP_JAL: begin is_jal = 1'b1; imm32 = imm_j; end
            default: dec_illegal = 1'b1;
        endcase
    end

    // Branch/jump offsets are byte offsets; the PC counts words.
    assign off_words = $signed(imm32) >>> 2;
    assign taken     = ~dec_illegal & is_br & (funct3[0] ? ~zero : zero);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: begin
                if (imem.imem_valid) begin
                    ir_d    = imem.imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                pc_d = (taken || (is_jal && !dec_illegal)) ? pc_q + PC_WIDTH'(off_words)
                                                           : pc_q + PC_WIDTH'(1);
                if (is_lw && !dec_illegal) begin
                    state_d = S_LOAD_WT;
                    cnt_d   = CNT_W'(LOAD_WAIT - 1);
                end
`ifdef ILLEGAL_TRAP_EN
                else if (dec_illegal) begin
                    state_d = S_HALT;
                    pc_d    = pc_q;
                end
`endif
                else begin
                    state_d = S_FETCH;
                end
            end
            S_LOAD_WT: begin
                if (cnt_q == '0) state_d = S_FETCH;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    logic in_exec, legal_exec;
    assign in_exec    = (state_q == S_EXEC);
    assign legal_exec = in_exec & ~dec_illegal;

    always_comb begin
        imem.imem_req  = (state_q == S_FETCH);
        imem.imem_addr = pc_q;
        pc          = pc_q;
        rs1         = RS_WIDTH'(ir_q[19:15]);
        rs2         = RS_WIDTH'(ir_q[24:20]);
        rd          = RS_WIDTH'(ir_q[11:7]);
        imm         = IMM_WIDTH'(imm32);
        instr_valid = in_exec;
        alu_control = legal_exec ? dec_alu : '0;
        alu_src     = legal_exec & (is_lw | is_sw | is_i);
        mem_to_reg  = legal_exec & is_lw;
        mem_write   = legal_exec & is_sw;
        reg_write   = legal_exec & (is_lw | is_r | is_i | is_jal);
        jal_src     = legal_exec & is_jal;
        ra          = (legal_exec && is_jal) ? pc_q + PC_WIDTH'(1) : '0;
        stall       = (state_q == S_LOAD_WT);
`ifdef ILLEGAL_TRAP_EN
        illegal     = (state_q == S_HALT);
`else
        illegal     = 1'b0;
`endif
    end
endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Directed, table-driven bench for fetch_decode_ctrl (PC_WIDTH=8, LOAD_WAIT=2, RESET_PC=0).
module tb_fetch_decode_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       zero;
    logic [4:0] rs1, rs2, rd;
    logic [11:0] imm;
    logic [3:0] alu_control;
    logic       alu_src, mem_to_reg, mem_write, reg_write, jal_src;
    logic [7:0] ra, pc;
    logic       instr_valid, stall, illegal;

    int n_checks = 0;
    int n_errors = 0;

    fetch_decode_ctrl_if #(.PC_WIDTH(8), .WIDTH(32)) imem ();

    fetch_decode_ctrl #(
        .PC_WIDTH(8), .WIDTH(32), .IMM_WIDTH(12), .RS_WIDTH(5), .ALU_WIDTH(4),
        .LOAD_WAIT(2), .RESET_PC(8'd0)
    ) dut (
        .clk(clk), .reset(reset), .imem(imem), .zero(zero),
        .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .alu_control(alu_control),
        .alu_src(alu_src), .mem_to_reg(mem_to_reg), .mem_write(mem_write),
        .reg_write(reg_write), .jal_src(jal_src), .ra(ra), .pc(pc),
        .instr_valid(instr_valid), .stall(stall), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          lat;
        logic [7:0]  pc;
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [3:0]  alu;
        logic [4:0]  ctl;     // {alu_src, mem_to_reg, mem_write, reg_write, jal_src}
        logic [7:0]  ra;
        logic [7:0]  next_pc;
        logic        is_load;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4:0] ctl_now();
        return {alu_src, mem_to_reg, mem_write, reg_write, jal_src};
    endfunction

    task automatic wait_req(input logic [7:0] exp_pc);
        int n = 0;
        while (imem.imem_req !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("fetch_req", imem.imem_req, 1);
        check("fetch_addr", imem.imem_addr, exp_pc);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        wait_req(v.pc);
        for (int i = 0; i < v.lat; i++) @(negedge clk);
        imem.imem_valid = 1'b1;
        imem.imem_rdata = v.instr;
        zero = v.zero;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        imem.imem_rdata = 32'hDEAD_BEEF;
        check($sformatf("v%0d_valid", idx), instr_valid, 1);
        check($sformatf("v%0d_rd", idx), rd, v.rd);
        check($sformatf("v%0d_rs1", idx), rs1, v.rs1);
        check($sformatf("v%0d_rs2", idx), rs2, v.rs2);
        check($sformatf("v%0d_imm", idx), imm, v.imm);
        check($sformatf("v%0d_alu", idx), alu_control, v.alu);
        check($sformatf("v%0d_ctl", idx), ctl_now(), v.ctl);
        check($sformatf("v%0d_ra", idx), ra, v.ra);
        @(negedge clk);
        check($sformatf("v%0d_next_pc", idx), pc, v.next_pc);
        check($sformatf("v%0d_post_ctl", idx), {ctl_now(), instr_valid}, 6'b0);
        if (v.is_load) begin
            check($sformatf("v%0d_stall1", idx), {stall, imem.imem_req}, 2'b10);
            @(negedge clk);
            check($sformatf("v%0d_stall2", idx), {stall, imem.imem_req}, 2'b10);
            @(negedge clk);
            check($sformatf("v%0d_stall_end", idx), {stall, imem.imem_req}, 2'b01);
        end else begin
            check($sformatf("v%0d_no_stall", idx), stall, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //            instr          z     lat pc      rd     rs1    rs2    imm       alu    ctl       ra     next    load
        vecs[0]  = '{32'h00500093, 1'b0, 1, 8'd0,   5'd1,  5'd0,  5'd5,  12'h005, 4'h2, 5'b10010, 8'd0,  8'd1,   1'b0}; // ADDI
        vecs[1]  = '{32'h0040A103, 1'b0, 0, 8'd1,   5'd2,  5'd1,  5'd4,  12'h004, 4'h2, 5'b11010, 8'd0,  8'd2,   1'b1}; // LW
        vecs[2]  = '{32'h002081B3, 1'b0, 2, 8'd2,   5'd3,  5'd1,  5'd2,  12'h000, 4'h2, 5'b00010, 8'd0,  8'd3,   1'b0}; // ADD
        vecs[3]  = '{32'h00000463, 1'b1, 0, 8'd3,   5'd8,  5'd0,  5'd0,  12'h008, 4'h6, 5'b00000, 8'd0,  8'd5,   1'b0}; // BEQ taken
        vecs[4]  = '{32'h00001463, 1'b1, 1, 8'd5,   5'd8,  5'd0,  5'd0,  12'h008, 4'h6, 5'b00000, 8'd0,  8'd6,   1'b0}; // BNE not
        vecs[5]  = '{32'hFFDFF0EF, 1'b0, 0, 8'd6,   5'd1,  5'd31, 5'd29, 12'hFFC, 4'h0, 5'b00011, 8'd7,  8'd5,   1'b0}; // JAL -4
        vecs[6]  = '{32'h00000463, 1'b0, 3, 8'd5,   5'd8,  5'd0,  5'd0,  12'h008, 4'h6, 5'b00000, 8'd0,  8'd6,   1'b0}; // BEQ not
        vecs[7]  = '{32'h00001463, 1'b0, 0, 8'd6,   5'd8,  5'd0,  5'd0,  12'h008, 4'h6, 5'b00000, 8'd0,  8'd8,   1'b0}; // BNE taken
        vecs[8]  = '{32'h00202423, 1'b0, 1, 8'd8,   5'd8,  5'd0,  5'd2,  12'h008, 4'h2, 5'b10100, 8'd0,  8'd9,   1'b0}; // SW
        vecs[9]  = '{32'hFFF0C293, 1'b0, 0, 8'd9,   5'd5,  5'd1,  5'd31, 12'hFFF, 4'h4, 5'b10010, 8'd0,  8'd10,  1'b0}; // XORI -1
        vecs[10] = '{32'hFD5FF06F, 1'b0, 2, 8'd10,  5'd0,  5'd31, 5'd21, 12'hFD4, 4'h0, 5'b00011, 8'd11, 8'd255, 1'b0}; // JAL -44
        vecs[11] = '{32'h00F1E213, 1'b0, 0, 8'd255, 5'd4,  5'd3,  5'd15, 12'h00F, 4'h1, 5'b10010, 8'd0,  8'd0,   1'b0}; // ORI, wrap
        vecs[12] = '{32'h003272B3, 1'b0, 1, 8'd0,   5'd5,  5'd4,  5'd3,  12'h000, 4'h0, 5'b00010, 8'd0,  8'd1,   1'b0}; // AND
        vecs[13] = '{32'h40208333, 1'b0, 0, 8'd1,   5'd6,  5'd1,  5'd2,  12'h000, 4'h6, 5'b00010, 8'd0,  8'd2,   1'b0}; // SUB
        vecs[14] = '{32'h0020D3B3, 1'b0, 1, 8'd2,   5'd7,  5'd1,  5'd2,  12'h000, 4'h3, 5'b00010, 8'd0,  8'd3,   1'b0}; // SRL

        reset = 1'b0;
        zero = 1'b0;
        imem.imem_valid = 1'b0;
        imem.imem_rdata = '0;
        #3;
        check("rst_pc", pc, 0);
        check("rst_addr", imem.imem_addr, 0);
        check("rst_outs", {imem.imem_req, instr_valid, stall, illegal, ctl_now(), alu_control, ra, rd, rs1, rs2, imm},
              '0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

        // Illegal opcode at pc=3.
        wait_req(8'd3);
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        imem.imem_valid = 1'b0;
        check("ill_exec_valid", instr_valid, 1);
        check("ill_exec_ctl", {ctl_now(), alu_control, ra}, '0);
        check("ill_exec_rd", rd, 5'd31);
        @(negedge clk);
`ifdef ILLEGAL_TRAP_EN
        check("ill_halt", {illegal, imem.imem_req, stall}, 3'b100);
        check("ill_halt_pc", pc, 3);
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 32'h00500093;
        for (int i = 0; i < 12; i++) @(negedge clk);
        check("ill_hold_pc", pc, 3);
        check("ill_hold", {illegal, imem.imem_req, instr_valid}, 3'b100);
`else
        check("ill_nop_pc", pc, 4);
        check("ill_nop_flags", {illegal, imem.imem_req}, 2'b01);
        imem.imem_valid = 1'b1;
        imem.imem_rdata = 32'h00500093;
`endif

        // Reset mid-operation with a valid response held on the bus.
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pc", pc, 0);
        check("mid_rst_outs", {imem.imem_req, instr_valid, stall, illegal, ctl_now(), rd, imm}, '0);
        @(negedge clk);
        check("mid_rst_hold_ir", rd, 0);
        reset = 1'b1;
        @(negedge clk);
        check("post_rst_no_capture", {rd, instr_valid}, '0);
        check("post_rst_req", imem.imem_req, 1);
        imem.imem_valid = 1'b0;
        run_vec(99, vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
